// File: rtl/pc_sequencer_if.sv
// Bus between the microcode host/control logic and the PC sequencer.
// Groups the step/branch request inputs and the next-address mux operands.
interface pc_sequencer_if #(
  parameter int ADDR_BITS   = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_BITS = $clog2(STACK_DEPTH) + 1;

  // step is the only transfer qualifier: a request (jump/call/ret/target) is
  // consumed exactly on a rising edge where step=1 and the sequencer is in RUN
  // with no halt_req; there is no back-pressure, so with step=0 or outside RUN
  // the request lines are ignored and need not be held.
  logic                 step;
  logic                 jump;
  logic                 call;
  logic                 ret;
  logic [ADDR_BITS-1:0] target;
  logic                 halt_req;
  logic                 resume;

  logic [ADDR_BITS-1:0] pc;
  logic [ADDR_BITS-1:0] pc_inc;
  logic [ADDR_BITS-1:0] pc_target;
  logic                 sel;
  logic                 running;
  logic                 fault;
  logic [SP_BITS-1:0]   sp;
  logic [1:0]           dbg_state;

  modport master (
    output step, jump, call, ret, target, halt_req, resume,
    input  pc, pc_inc, pc_target, sel, running, fault, sp, dbg_state
  );

  modport slave (
    input  step, jump, call, ret, target, halt_req, resume,
    output pc, pc_inc, pc_target, sel, running, fault, sp, dbg_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds pc, feeds the 2:1 next-address mux and
// manages a small return stack under a run/halt/fault state machine.
module pc_sequencer #(
  parameter int ADDR_BITS   = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);
  localparam int SP_BITS  = $clog2(STACK_DEPTH) + 1;
  localparam int PTR_BITS = $clog2(STACK_DEPTH);
  localparam logic [ADDR_BITS-1:0] RST_PC = ADDR_BITS'(RESET_ADDR);
  localparam logic [SP_BITS-1:0]   SP_FULL = SP_BITS'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] pc_q;
  logic [SP_BITS-1:0]   sp_q;
  logic                 running_q;
  logic                 fault_q;
  logic [ADDR_BITS-1:0] stack [STACK_DEPTH];

  logic                 advance;
  logic                 ret_take;
  logic                 call_take;
  logic                 jump_take;
  logic                 stack_err;
  logic [PTR_BITS-1:0]  top_idx;
  logic [PTR_BITS-1:0]  push_idx;
  logic [ADDR_BITS-1:0] pc_inc;
  logic [ADDR_BITS-1:0] pc_target;
  logic                 sel;

  always_comb begin
    advance   = (state == ST_RUN) && !bus.halt_req && bus.step;
    top_idx   = sp_q[PTR_BITS-1:0] - PTR_BITS'(1);
    push_idx  = sp_q[PTR_BITS-1:0];
    pc_inc    = pc_q + ADDR_BITS'(1);
    // Requests are decoded in ret > call > jump priority; a ret or call that
    // would break the stack is not taken and instead raises the fault.
    ret_take  = advance && bus.ret && (sp_q != '0);
    call_take = advance && !bus.ret && bus.call && (sp_q != SP_FULL);
    jump_take = advance && !bus.ret && !bus.call && bus.jump;
    stack_err = advance && ((bus.ret && (sp_q == '0)) ||
                            (!bus.ret && bus.call && (sp_q == SP_FULL)));
    sel       = ret_take || call_take || jump_take;
    pc_target = ret_take ? stack[top_idx] : bus.target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      pc_q      <= RST_PC;
      sp_q      <= '0;
      running_q <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.halt_req) begin
            state     <= ST_HALT;
            running_q <= 1'b0;
          end else if (stack_err) begin
            state     <= ST_FAULT;
            running_q <= 1'b0;
            fault_q   <= 1'b1;
          end else if (advance) begin
            // Register update uses the same operands the external mux sees.
            pc_q <= sel ? pc_target : pc_inc;
            if (ret_take) begin
              sp_q <= sp_q - SP_BITS'(1);
            end else if (call_take) begin
              stack[push_idx] <= pc_inc;
              sp_q            <= sp_q + SP_BITS'(1);
            end
          end
        end
        ST_HALT: begin
          if (bus.resume && !bus.halt_req) begin
            state     <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_FAULT: begin
          if (bus.resume) begin
            state     <= ST_RUN;
            pc_q      <= RST_PC;
            sp_q      <= '0;
            running_q <= 1'b1;
            fault_q   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_FAULT;
          running_q <= 1'b0;
          fault_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_inc    = pc_inc;
  assign bus.pc_target = pc_target;
  assign bus.sel       = sel;
  assign bus.running   = running_q;
  assign bus.fault     = fault_q;
  assign bus.sp        = sp_q;
  assign bus.dbg_state = state;
endmodule
